clken_gen: RTL and testbench
============================

CLKEN_GEN -- requirements
Module: clken_gen

Interface
REQ-001 Parameter NUM_CH, default 2, number of clock-enable channels (1..8).
REQ-002 Parameter ACC_W, default 24, phase-accumulator width in bits (8..32).
REQ-003 Parameter LOCK_CNT, default 1024, settle cycles before locked asserts (>=2).
REQ-004 Parameter INC0, default 24'd5359993, reset increment of every channel (about 15.974 MHz ce rate at a 50.0 MHz refclk).
REQ-005 Port refclk, input, 1, sole clock; all logic is on its rising edge.
REQ-006 Port rst_n, input, 1, reset; asynchronous, active-low.
REQ-007 Port ch_en, input, NUM_CH, per-channel run enable.
REQ-008 Port cfg_valid, input, 1, reconfiguration request.
REQ-009 Port cfg_ready, output, 1, request can be accepted.
REQ-010 Port cfg_ch, input, max(1,clog2(NUM_CH)), target channel index.
REQ-011 Port cfg_inc, input, ACC_W, new increment for the target channel.
REQ-012 Port ce_out, output, NUM_CH, one-refclk-cycle enable pulses, registered.
REQ-013 Port locked, output, 1, all channels stable at configured rates.

Function
REQ-014 Each channel SHALL hold an ACC_W-bit accumulator acc[i] and increment register inc[i].
REQ-015 While ch_en[i]=1, each cycle: sum = acc[i]+inc[i] in ACC_W+1 bits; acc[i] <= sum mod 2^ACC_W; ce_out[i] <= sum[ACC_W] (carry).
REQ-016 Resulting ce rate SHALL be f_refclk*inc/2^ACC_W; inc=0 gives no pulses.
REQ-017 While ch_en[i]=0: acc[i] <= 0 and ce_out[i] <= 0; inc[i] is retained.
REQ-018 A handshake SHALL transfer only when cfg_valid=1 and cfg_ready=1 on the same edge; cfg_ch and cfg_inc are captured at that edge.
REQ-019 Control FSM states: SETTLE, IDLE, PEND.
REQ-020 cfg_ready SHALL be 1 in SETTLE and IDLE, and 0 in PEND.
REQ-021 locked SHALL be 1 only in IDLE.
REQ-022 SETTLE: count from 0; after LOCK_CNT cycles with no accepted request, go to IDLE.
REQ-023 Accept with a valid cfg_ch (< NUM_CH), from IDLE or SETTLE: go to PEND, and hold the captured channel and increment as pending.
REQ-024 Accept with cfg_ch >= NUM_CH: request is discarded; state, counter and locked are unchanged.
REQ-025 PEND with the target channel enabled: on the first cycle its carry is 1, inc is replaced by the pending value; go to SETTLE with count 0. That cycle's accumulation uses the old inc, so the update is glitch-free.
REQ-026 PEND with the target channel disabled: the pending increment is written on the next edge, then go to SETTLE.
REQ-027 ch_en of the target falling during PEND: the rule in REQ-026 applies from that cycle.
REQ-028 Accept in SETTLE SHALL restart the settle count from 0 after the update completes; locked stays 0 throughout.
REQ-029 Non-target channels SHALL run undisturbed during PEND and SETTLE.
REQ-030 Settle counter width: clog2(LOCK_CNT+1); it SHALL saturate at LOCK_CNT, never wrap.

Reset
REQ-031 rst_n=0 SHALL immediately force: acc=0, inc=INC0 for all channels, ce_out=0, pending cleared, state SETTLE with count 0, locked=0, cfg_ready=1.
REQ-032 rst_n asserted mid-PEND SHALL discard the pending request; inc reverts to INC0.
REQ-033 Reset release is synchronised by the parent; the block SHALL not glitch any output during reset.

Verification (ACC_W=8, NUM_CH=2, LOCK_CNT=16, INC0=128)
REQ-034 Release reset, ch_en=2'b11 -> ce_out[0] and ce_out[1] pulse every 2nd cycle; locked rises exactly 16 cycles after release.
REQ-035 Locked, send cfg_ch=0, cfg_inc=64 -> cfg_ready=0 and locked=0 next cycle; inc updates on the ch0 carry cycle; ch0 then pulses every 4th cycle with no short interval; ch1 unchanged; locked returns 16 cycles after the update.
REQ-036 ch_en[1]=0, send cfg_ch=1, cfg_inc=32 -> update completes in 1 cycle, ce_out[1] stays 0; re-enable -> first pulse 8 cycles later, then every 8.
REQ-037 cfg_ch=3, cfg_valid=1 while locked -> accepted; no change to state, locked or rates.
REQ-038 rst_n low during PEND -> all outputs reset at once; after release, both channels run at inc=128 and the pending value is never applied.
REQ-039 cfg_inc=0 on ch0 -> ce_out[0] stays 0 permanently; locked reasserts after 16 cycles.

Source files
------------

// File: rtl/clken_gen.sv
// clken_gen: per-channel phase-accumulator clock-enable generators with a
// handshake-driven, glitch-free increment retune and settle/lock tracking.

module clken_ch #(
   parameter int               ACC_W = 24,
   parameter logic [ACC_W-1:0] INC0  = '0
) (
   input  logic             refclk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             inc_we,
   input  logic [ACC_W-1:0] inc_wdata,
   output logic             carry,
   output logic             inc_zero,
   output logic             ce
);
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [ACC_W-1:0] inc_q, inc_d;
   logic             ce_q, ce_d;
   logic [ACC_W:0]   sum;

   // carry is exposed combinationally so the retune lands on the same edge
   // that emits the pulse computed with the old increment
   always_comb begin
      sum      = {1'b0, acc_q} + {1'b0, inc_q};
      carry    = en & sum[ACC_W];
      inc_zero = (inc_q == '0);
      acc_d    = en ? sum[ACC_W-1:0] : '0;
      ce_d     = carry;
      inc_d    = inc_we ? inc_wdata : inc_q;
   end

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
         inc_q <= INC0;
         ce_q  <= 1'b0;
      end else begin
         acc_q <= acc_d;
         inc_q <= inc_d;
         ce_q  <= ce_d;
      end
   end

   assign ce = ce_q;
endmodule

module clken_gen #(
   parameter int               NUM_CH   = 2,
   parameter int               ACC_W    = 24,
   parameter int               LOCK_CNT = 1024,
   parameter logic [ACC_W-1:0] INC0     = ACC_W'(24'd5359993),
   localparam int              CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              refclk,
   input  logic              rst_n,
   input  logic [NUM_CH-1:0] ch_en,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [ACC_W-1:0]  cfg_inc,
   output logic [NUM_CH-1:0] ce_out,
   output logic              locked
);
   localparam int CNT_W = $clog2(LOCK_CNT + 1);

   typedef enum logic [1:0] {SETTLE, IDLE, PEND} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [CH_W-1:0]    pend_ch_q, pend_ch_d;
   logic [ACC_W-1:0]   pend_inc_q, pend_inc_d;
   logic               locked_q, locked_d;
   logic               ready_q, ready_d;

   logic [NUM_CH-1:0]  carry, inc_zero, inc_we;
   logic               accept, ch_ok, tgt_en, tgt_carry, tgt_zero, upd;

   genvar g;
   generate
      for (g = 0; g < NUM_CH; g++) begin : g_ch
         clken_ch #(.ACC_W(ACC_W), .INC0(INC0)) u_ch (
            .refclk    (refclk),
            .rst_n     (rst_n),
            .en        (ch_en[g]),
            .inc_we    (inc_we[g]),
            .inc_wdata (pend_inc_q),
            .carry     (carry[g]),
            .inc_zero  (inc_zero[g]),
            .ce        (ce_out[g])
         );
      end
   endgenerate

   // A target with inc=0 never carries; applying at once avoids a stuck PEND
   // and cannot disturb a pulse stream that does not exist.
   always_comb begin
      tgt_en    = 1'b0;
      tgt_carry = 1'b0;
      tgt_zero  = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (pend_ch_q == CH_W'(i)) begin
            tgt_en    = ch_en[i];
            tgt_carry = carry[i];
            tgt_zero  = inc_zero[i];
         end
      end
      upd    = (state_q == PEND) && (!tgt_en || tgt_carry || tgt_zero);
      inc_we = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         inc_we[i] = upd && (pend_ch_q == CH_W'(i));
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      pend_ch_d  = pend_ch_q;
      pend_inc_d = pend_inc_q;
      accept     = cfg_valid && ready_q;
      ch_ok      = 32'(cfg_ch) < NUM_CH;
      case (state_q)
         SETTLE: begin
            if (accept && ch_ok) begin
               state_d    = PEND;
               pend_ch_d  = cfg_ch;
               pend_inc_d = cfg_inc;
            end else begin
               if (cnt_q < CNT_W'(LOCK_CNT)) cnt_d = cnt_q + 1'b1;
               if (cnt_q == CNT_W'(LOCK_CNT - 1)) state_d = IDLE;
            end
         end
         IDLE: begin
            if (accept && ch_ok) begin
               state_d    = PEND;
               pend_ch_d  = cfg_ch;
               pend_inc_d = cfg_inc;
            end
         end
         PEND: begin
            if (upd) begin
               state_d = SETTLE;
               cnt_d   = '0;
            end
         end
         default: state_d = SETTLE;
      endcase
      locked_d = (state_d == IDLE);
      ready_d  = (state_d != PEND);
   end

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= SETTLE;
         cnt_q      <= '0;
         pend_ch_q  <= '0;
         pend_inc_q <= '0;
         locked_q   <= 1'b0;
         ready_q    <= 1'b1;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         pend_ch_q  <= pend_ch_d;
         pend_inc_q <= pend_inc_d;
         locked_q   <= locked_d;
         ready_q    <= ready_d;
      end
   end

   assign locked    = locked_q;
   assign cfg_ready = ready_q;
endmodule

// File: tb/tb_clken_gen.sv
// Randomised and directed bench for clken_gen against an integer reference
// model of accumulator rates, pending retunes and settle age.

module tb_clken_gen;
   localparam int NCH  = 3;
   localparam int AW   = 8;
   localparam int LOCK = 16;
   localparam int MOD  = 256;

   logic           refclk = 1'b0;
   logic           rst_n;
   logic [NCH-1:0] ch_en;
   logic           cfg_valid;
   logic           cfg_ready;
   logic [1:0]     cfg_ch;
   logic [AW-1:0]  cfg_inc;
   logic [NCH-1:0] ce_out;
   logic           locked;

   int checks = 0;
   int errors = 0;

   // reference model: integer accumulators, pending request, cycles since update
   int             m_acc [NCH];
   int             m_inc [NCH];
   logic [NCH-1:0] m_ce;
   bit             m_pend;
   int             m_pch, m_pinc, m_age;

   clken_gen #(.NUM_CH(NCH), .ACC_W(AW), .LOCK_CNT(LOCK), .INC0(8'd128)) dut (
      .refclk    (refclk),
      .rst_n     (rst_n),
      .ch_en     (ch_en),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_ch    (cfg_ch),
      .cfg_inc   (cfg_inc),
      .ce_out    (ce_out),
      .locked    (locked)
   );

   always #5 refclk = ~refclk;

   function automatic logic [NCH+1:0] exp_vec();
      return {m_ce, (!m_pend && m_age >= LOCK), ~m_pend};
   endfunction

   function automatic logic [NCH+1:0] got_vec();
      return {ce_out, locked, cfg_ready};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NCH; i++) begin
         m_acc[i] = 0;
         m_inc[i] = 128;
      end
      m_ce   = '0;
      m_pend = 0;
      m_age  = 0;
   endtask

   task automatic model_step();
      bit cy [NCH];
      for (int i = 0; i < NCH; i++) begin
         cy[i] = 0;
         if (ch_en[i]) begin
            cy[i]    = (m_acc[i] + m_inc[i]) >= MOD;
            m_acc[i] = (m_acc[i] + m_inc[i]) % MOD;
         end else begin
            m_acc[i] = 0;
         end
         m_ce[i] = cy[i];
      end
      if (m_pend) begin
         if (!ch_en[m_pch] || cy[m_pch] || m_inc[m_pch] == 0) begin
            m_inc[m_pch] = m_pinc;
            m_pend = 0;
            m_age  = 0;
         end
      end else if (cfg_valid && int'(cfg_ch) < NCH) begin
         m_pend = 1;
         m_pch  = int'(cfg_ch);
         m_pinc = int'(cfg_inc);
      end else begin
         m_age++;
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge refclk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      @(posedge refclk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic send(input int ch, input int inc);
      cfg_valid = 1'b1;
      cfg_ch    = 2'(ch);
      cfg_inc   = 8'(inc);
   endtask

   task automatic test_reset();
      rst_n = 1'b1; ch_en = '0; cfg_valid = 1'b0; cfg_ch = '0; cfg_inc = '0;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (got_vec() !== 5'b00001) begin
         errors++;
         $display("FAIL reset_async got=%b want=00001", got_vec());
      end
      model_reset();
      @(posedge refclk);
      #1;
      checks++;
      if (got_vec() !== 5'b00001) begin
         errors++;
         $display("FAIL reset_held got=%b want=00001", got_vec());
      end
      rst_n = 1'b1;
   endtask

   task automatic test_run();
      ch_en = 3'b011;
      for (int c = 0; c < 24; c++) begin
         tick();
         checks++;
         if (got_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL run cyc=%0d got=%b want=%b", c, got_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_retune();
      send(0, 64);
      for (int c = 0; c < 40; c++) begin
         tick();
         cfg_valid = 1'b0;
         checks++;
         if (got_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL retune cyc=%0d got=%b want=%b", c, got_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_disabled_update();
      ch_en = 3'b001;
      tick();
      send(1, 32);
      for (int c = 0; c < 50; c++) begin
         tick();
         cfg_valid = 1'b0;
         if (c == 4) ch_en = 3'b011;
         checks++;
         if (got_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL dis_upd cyc=%0d got=%b want=%b", c, got_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_bad_ch();
      send(3, 17);
      for (int c = 0; c < 12; c++) begin
         tick();
         cfg_valid = 1'b0;
         checks++;
         if (got_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL bad_ch cyc=%0d got=%b want=%b", c, got_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_zero_inc();
      send(0, 0);
      for (int c = 0; c < 40; c++) begin
         tick();
         cfg_valid = 1'b0;
         checks++;
         if (got_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL zero_inc cyc=%0d got=%b want=%b", c, got_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_reset_pend();
      for (int c = 0; c < 20; c++) tick();
      ch_en = 3'b010;
      tick();
      ch_en = 3'b011;
      send(1, 200);
      tick();
      cfg_valid = 1'b0;
      checks++;
      if (cfg_ready !== 1'b0) begin
         errors++;
         $display("FAIL pend_entry cfg_ready=%b want=0", cfg_ready);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (got_vec() !== 5'b00001) begin
         errors++;
         $display("FAIL reset_pend got=%b want=00001", got_vec());
      end
      model_reset();
      @(posedge refclk);
      #1;
      rst_n = 1'b1;
      for (int c = 0; c < 30; c++) begin
         tick();
         checks++;
         if (got_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL post_reset cyc=%0d got=%b want=%b", c, got_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_random();
      ch_en = 3'b111;
      for (int c = 0; c < 4000; c++) begin
         int k;
         k = $urandom_range(0, NCH - 1);
         if ($urandom_range(0, 29) == 0) ch_en[k] = ~ch_en[k];
         cfg_valid = ($urandom_range(0, 5) == 0);
         cfg_ch    = 2'($urandom_range(0, 3));
         cfg_inc   = 8'($urandom_range(1, 255));
         if ($urandom_range(0, 799) == 0) do_reset();
         else tick();
         checks++;
         if (got_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL random cyc=%0d got=%b want=%b", c, got_vec(), exp_vec());
         end
      end
   endtask

   initial begin
      test_reset();
      test_run();
      test_retune();
      test_disabled_update();
      test_bad_ch();
      test_zero_inc();
      test_reset_pend();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
